// File: rtl/bit_deser_if.sv
// -----------------------------------------------------------------------------
// bit_deser_if -- signal bundle for the bit_deser serial-to-parallel block.
//
// Groups the serial input side (in_valid, sum_bit, carry_bit), the word output
// handshake (out_ready, out_valid, out_word, out_carry) and the status flags
// (overflow, busy).
//
// Modports:
//   master : the environment around the deserialiser. It drives the serial
//            input and out_ready, and observes the word and status outputs.
//   slave  : the deserialiser itself. It is the mirror image of master.
//
// Optional feature:
//   BIT_DESER_PARITY_EN adds out_parity (XOR of out_word) to the bundle.
// -----------------------------------------------------------------------------
interface bit_deser_if #(
  parameter int WIDTH = 8
) ();

  // Serial input side.
  logic             in_valid;
  logic             sum_bit;
  logic             carry_bit;

  // Word output side.
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_word;
  logic             out_carry;

  // Status.
  logic             overflow;
  logic             busy;

`ifdef BIT_DESER_PARITY_EN
  logic             out_parity;
`endif

  modport master (
    output in_valid,
    output sum_bit,
    output carry_bit,
    output out_ready,
    input  out_valid,
    input  out_word,
    input  out_carry,
`ifdef BIT_DESER_PARITY_EN
    input  out_parity,
`endif
    input  overflow,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  sum_bit,
    input  carry_bit,
    input  out_ready,
    output out_valid,
    output out_word,
    output out_carry,
`ifdef BIT_DESER_PARITY_EN
    output out_parity,
`endif
    output overflow,
    output busy
  );

endinterface : bit_deser_if

// File: rtl/bit_deser.sv
// -----------------------------------------------------------------------------
// bit_deser -- assembles a serial bit stream (LSB first) from an upstream
// registered adder stage into WIDTH-bit words, offered downstream through a
// valid/ready handshake with a single output holding register.
//
// Ports:
//   clk    : single clock, all state changes on the rising edge.
//   rst_n  : synchronous active-low reset; wins over every other input.
//   bus    : bit_deser_if.slave
//              in_valid/sum_bit/carry_bit  serial input, never back-pressured
//              out_ready                   consumer accepts the held word
//              out_valid/out_word/out_carry held word and its final carry
//              overflow                    sticky: a completed word was dropped
//              busy                        a partial word is being collected
//
// Configuration:
//   BIT_DESER_PARITY_EN  when defined, out_parity = XOR of the held out_word,
//                        loaded together with out_word and reset to 0.
//
// Behaviour summary:
//   Bits land in the shift register at index cnt. When bit WIDTH-1 arrives the
//   finished word (including that cycle's bit) plus carry_bit is complete. It
//   loads the output register on the next edge if the register is empty or is
//   being emptied in the same cycle; otherwise it is dropped and overflow sets.
// -----------------------------------------------------------------------------
module bit_deser #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  bit_deser_if.slave  bus
);

  // Enough bits to count 0..WIDTH-1.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  // Output holding register state: EMPTY <=> out_valid = 0.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] shreg_q,    shreg_d;
  out_state_e       state_q,    state_d;
  logic [WIDTH-1:0] word_q,     word_d;
  logic             carry_q,    carry_d;
  logic             overflow_q, overflow_d;
`ifdef BIT_DESER_PARITY_EN
  logic             parity_q,   parity_d;
`endif

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic             last_bit;   // this cycle's bit finishes a word
  logic             xfer;       // consumer takes the held word this cycle
  logic [WIDTH-1:0] assembled;  // shift register with this cycle's bit merged

  assign last_bit = bus.in_valid && (cnt_q == LAST_IDX);
  assign xfer     = (state_q == FULL) && bus.out_ready;

  // The completing bit is not yet in shreg_q, so the word handed to the output
  // register must merge it in combinationally.
  always_comb begin
    assembled          = shreg_q;
    assembled[cnt_q]   = bus.sum_bit;
  end

  // ---------------------------------------------------------------------------
  // Serial collection: runs regardless of the output state.
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in an always_comb gets its default on the
  // first lines; a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (bus.in_valid) begin
      if (last_bit) begin
        cnt_d   = '0;
        shreg_d = '0;  // start the next word from a clean register
      end else begin
        cnt_d   = cnt_q + 1'b1;
        shreg_d = assembled;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output control FSM: next state and holding-register loads.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
`ifdef BIT_DESER_PARITY_EN
    parity_d   = parity_q;
`endif

    unique case (state_q)
      EMPTY: begin
        if (last_bit) begin
          state_d = FULL;
          word_d  = assembled;
          carry_d = bus.carry_bit;
`ifdef BIT_DESER_PARITY_EN
          parity_d = ^assembled;
`endif
        end
      end

      FULL: begin
        if (last_bit) begin
          if (xfer) begin
            // Old word leaves and the new one takes its place in one edge,
            // so out_valid never drops.
            word_d  = assembled;
            carry_d = bus.carry_bit;
`ifdef BIT_DESER_PARITY_EN
            parity_d = ^assembled;
`endif
          end else begin
            // No room: keep the held word untouched and record the loss.
            overflow_d = 1'b1;
          end
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end

      default: state_d = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  // NOTE: the shift register is reset along with the control state so a
  // partial word from before reset can never leak into a later word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      shreg_q    <= '0;
      state_q    <= EMPTY;
      word_q     <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
`ifdef BIT_DESER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      state_q    <= state_d;
      word_q     <= word_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
`ifdef BIT_DESER_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.out_valid  = (state_q == FULL);
  assign bus.out_word   = word_q;
  assign bus.out_carry  = carry_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = (cnt_q != '0);
`ifdef BIT_DESER_PARITY_EN
  assign bus.out_parity = parity_q;
`endif

endmodule : bit_deser
